// File: rtl/game_tick_scheduler.sv
// Frame tick scheduler: divides clk into frame ticks and sequences up to three
// game steps (ball, paddles, render) per frame with timeout and overrun tracking.
module game_tick_scheduler #(
    parameter int TICK_DIV = 500000,
    parameter int TIMEOUT  = 4095
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [2:0]  step_en,
    input  logic [2:0]  step_done,
    input  logic        clr_err,
    output logic [2:0]  step_start,
    output logic        busy,
    output logic        tick,
    output logic [15:0] frame_cnt,
    output logic        overrun,
    output logic [7:0]  overrun_cnt,
    output logic        timeout_err
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t            state;
    logic [DIV_W-1:0]  div_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [2:0]        mask;
    logic [1:0]        idx;

    logic [1:0]        first_idx;
    logic [1:0]        next_idx;
    logic              has_next;
    logic              done_sel;
    logic              expired;
    logic              step_fire;
    logic              timeout_evt;
    logic              overrun_evt;

    // Step selection: only the done bit of the active step counts, and the next
    // step is the lowest mask bit above the current one.
    always_comb begin
        first_idx = 2'd2;
        if (step_en[0])
            first_idx = 2'd0;
        else if (step_en[1])
            first_idx = 2'd1;

        done_sel = 1'b0;
        has_next = 1'b0;
        next_idx = idx;
        case (idx)
            2'd0: begin
                done_sel = step_done[0];
                if (mask[1]) begin
                    has_next = 1'b1;
                    next_idx = 2'd1;
                end else if (mask[2]) begin
                    has_next = 1'b1;
                    next_idx = 2'd2;
                end
            end
            2'd1: begin
                done_sel = step_done[1];
                if (mask[2]) begin
                    has_next = 1'b1;
                    next_idx = 2'd2;
                end
            end
            2'd2: done_sel = step_done[2];
            default: done_sel = 1'b0;
        endcase

        expired     = (to_cnt == TO_LAST);
        step_fire   = (state == S_WAIT) && (done_sel || expired);
        timeout_evt = (state == S_WAIT) && !done_sel && expired;
        overrun_evt = tick && (state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            div_cnt     <= '0;
            to_cnt      <= '0;
            mask        <= '0;
            idx         <= '0;
            tick        <= 1'b0;
            step_start  <= '0;
            busy        <= 1'b0;
            frame_cnt   <= '0;
            overrun     <= 1'b0;
            overrun_cnt <= '0;
            timeout_err <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (!run) begin
                div_cnt <= '0;
            end else if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                tick    <= 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            // step_start is loaded on the transition into ISSUE so it is high
            // for exactly the ISSUE cycle.
            step_start <= '0;
            case (state)
                S_IDLE: begin
                    if (tick) begin
                        mask <= step_en;
                        if (step_en == 3'b000) begin
                            frame_cnt <= frame_cnt + 16'd1;
                        end else begin
                            idx        <= first_idx;
                            step_start <= 3'b001 << first_idx;
                            busy       <= 1'b1;
                            state      <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    to_cnt <= '0;
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (step_fire) begin
                        if (has_next) begin
                            idx        <= next_idx;
                            step_start <= 3'b001 << next_idx;
                            state      <= S_ISSUE;
                        end else begin
                            frame_cnt <= frame_cnt + 16'd1;
                            busy      <= 1'b0;
                            state     <= S_IDLE;
                        end
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase

            // A new error event beats a simultaneous clear.
            if (overrun_evt) begin
                overrun <= 1'b1;
                if (clr_err)
                    overrun_cnt <= 8'd1;
                else if (overrun_cnt != 8'hFF)
                    overrun_cnt <= overrun_cnt + 8'd1;
            end else if (clr_err) begin
                overrun     <= 1'b0;
                overrun_cnt <= '0;
            end

            if (timeout_evt)
                timeout_err <= 1'b1;
            else if (clr_err)
                timeout_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Directed bench for game_tick_scheduler with TICK_DIV=10, TIMEOUT=20; inputs
// change and outputs are sampled on the falling clock edge.
module tb_game_tick_scheduler;

    localparam int TICK_DIV = 10;
    localparam int TIMEOUT  = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [2:0]  step_en;
    logic [2:0]  step_done;
    logic        clr_err;
    logic [2:0]  step_start;
    logic        busy;
    logic        tick;
    logic [15:0] frame_cnt;
    logic        overrun;
    logic [7:0]  overrun_cnt;
    logic        timeout_err;

    int          compared   = 0;
    int          mismatched = 0;
    int          bad_start  = 0;
    logic [2:0]  seen_start = 3'b000;

    game_tick_scheduler #(
        .TICK_DIV (TICK_DIV),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .step_en     (step_en),
        .step_done   (step_done),
        .clr_err     (clr_err),
        .step_start  (step_start),
        .busy        (busy),
        .tick        (tick),
        .frame_cnt   (frame_cnt),
        .overrun     (overrun),
        .overrun_cnt (overrun_cnt),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic r, input logic rn, input logic [2:0] en,
                                 input logic [2:0] dn, input logic clr);
        rst       = r;
        run       = rn;
        step_en   = en;
        step_done = dn;
        clr_err   = clr;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Advance to the next falling edge, tracking step_start legality on the way.
    task automatic cycle();
        @(negedge clk);
        seen_start = seen_start | step_start;
        if (((step_start & (step_start - 3'd1)) != 3'b000) || (step_start != 3'b000 && !busy))
            bad_start++;
    endtask

    task automatic waitTick(input int limit, output int cycles);
        cycles = 0;
        do begin
            cycle();
            cycles++;
        end while (tick !== 1'b1 && cycles < limit);
    endtask

    task automatic waitIdle(input int limit);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < limit) begin
            cycle();
            n++;
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_step_start"}, 64'(step_start), 0);
        checkOutput({tag, "_busy"}, 64'(busy), 0);
        checkOutput({tag, "_tick"}, 64'(tick), 0);
        checkOutput({tag, "_frame_cnt"}, 64'(frame_cnt), 0);
        checkOutput({tag, "_overrun"}, 64'(overrun), 0);
        checkOutput({tag, "_overrun_cnt"}, 64'(overrun_cnt), 0);
        checkOutput({tag, "_timeout_err"}, 64'(timeout_err), 0);
    endtask

    initial begin
        int          n;
        int          ticks;
        logic        busy_seen;
        logic [63:0] tick_hist;

        applyStimulus(1'b1, 1'b0, 3'b000, 3'b000, 1'b0);
        repeat (3) cycle();
        checkResetValues("reset");
        applyStimulus(1'b0, 1'b0, 3'b000, 3'b000, 1'b0);
        repeat (2) cycle();

        // Empty frames: ticks at 10, 20, 30 and each one completes a frame at once.
        applyStimulus(1'b0, 1'b1, 3'b000, 3'b000, 1'b0);
        tick_hist = '0;
        busy_seen = 1'b0;
        for (int k = 1; k <= 35; k++) begin
            cycle();
            tick_hist[k] = tick;
            busy_seen    = busy_seen | busy;
        end
        checkOutput("div_tick_hist", tick_hist, 64'h4010_0400);
        checkOutput("empty_busy_never", 64'(busy_seen), 0);
        checkOutput("empty_frames", 64'(frame_cnt), 3);
        checkOutput("empty_no_start", 64'(seen_start), 0);
        applyStimulus(1'b0, 1'b0, 3'b000, 3'b000, 1'b0);
        repeat (3) cycle();

        // Ball + render frame, run dropped right after the tick.
        seen_start = 3'b000;
        applyStimulus(1'b0, 1'b1, 3'b101, 3'b000, 1'b0);
        waitTick(15, n);
        checkOutput("tick_latency_a", 64'(n), 10);
        applyStimulus(1'b0, 1'b0, 3'b101, 3'b000, 1'b0);
        cycle();
        checkOutput("start_ball", 64'(step_start), 3'b001);
        checkOutput("busy_issue", 64'(busy), 1);
        repeat (2) cycle();
        checkOutput("start_gap", 64'(step_start), 0);
        cycle();
        step_done = 3'b001;
        cycle();
        checkOutput("start_render", 64'(step_start), 3'b100);
        step_done = 3'b100;
        cycle();
        checkOutput("start_one_cycle", 64'(step_start), 0);
        step_done = 3'b001;
        cycle();
        checkOutput("done_in_issue_ignored", 64'(busy), 1);
        checkOutput("frame_not_yet", 64'(frame_cnt), 3);
        step_done = 3'b000;
        cycle();
        step_done = 3'b100;
        cycle();
        step_done = 3'b000;
        checkOutput("frame_done_cnt", 64'(frame_cnt), 4);
        checkOutput("frame_done_idle", 64'(busy), 0);
        checkOutput("no_paddle_start", 64'(seen_start), 3'b101);

        ticks = 0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (tick) ticks++;
        end
        checkOutput("no_tick_run_low", 64'(ticks), 0);

        // Ball-only frame that never finishes; step_en changes mid-frame.
        seen_start = 3'b000;
        applyStimulus(1'b0, 1'b1, 3'b001, 3'b000, 1'b0);
        waitTick(15, n);
        checkOutput("tick_latency_b", 64'(n), 10);
        applyStimulus(1'b0, 1'b0, 3'b001, 3'b000, 1'b0);
        cycle();
        checkOutput("start_ball_b", 64'(step_start), 3'b001);
        step_en = 3'b110;
        n = 0;
        do begin
            cycle();
            n++;
        end while (timeout_err !== 1'b1 && n < 40);
        checkOutput("timeout_latency", 64'(n), 21);
        checkOutput("timeout_idle", 64'(busy), 0);
        checkOutput("timeout_frame_cnt", 64'(frame_cnt), 5);
        checkOutput("timeout_mask_latched", 64'(seen_start), 3'b001);

        applyStimulus(1'b0, 1'b0, 3'b000, 3'b000, 1'b1);
        cycle();
        applyStimulus(1'b0, 1'b0, 3'b000, 3'b000, 1'b0);
        checkOutput("clr_timeout", 64'(timeout_err), 0);

        // Long stalled frames across ~310 ticks saturate the overrun counter.
        applyStimulus(1'b0, 1'b1, 3'b111, 3'b000, 1'b0);
        repeat (3100) cycle();
        applyStimulus(1'b0, 1'b0, 3'b111, 3'b000, 1'b0);
        waitIdle(100);
        checkOutput("sat_drained", 64'(busy), 0);
        checkOutput("sat_overrun", 64'(overrun), 1);
        checkOutput("sat_overrun_cnt", 64'(overrun_cnt), 255);
        checkOutput("sat_timeout", 64'(timeout_err), 1);
        applyStimulus(1'b0, 1'b0, 3'b000, 3'b000, 1'b1);
        cycle();
        applyStimulus(1'b0, 1'b0, 3'b000, 3'b000, 1'b0);
        checkOutput("clr_overrun", 64'(overrun), 0);
        checkOutput("clr_overrun_cnt", 64'(overrun_cnt), 0);
        checkOutput("clr_timeout_all", 64'(timeout_err), 0);

        // Clear on the same cycle as a dropped tick: the event wins.
        applyStimulus(1'b0, 1'b1, 3'b001, 3'b000, 1'b0);
        waitTick(15, n);
        waitTick(15, n);
        cycle();
        checkOutput("overrun_first", 64'(overrun_cnt), 1);
        waitTick(15, n);
        clr_err = 1'b1;
        cycle();
        clr_err = 1'b0;
        checkOutput("clr_vs_event_cnt", 64'(overrun_cnt), 1);
        checkOutput("clr_vs_event_flag", 64'(overrun), 1);
        run = 1'b0;
        waitIdle(100);

        // Reset in the middle of a WAIT abandons the frame.
        applyStimulus(1'b0, 1'b1, 3'b001, 3'b000, 1'b0);
        waitTick(15, n);
        applyStimulus(1'b0, 1'b0, 3'b001, 3'b000, 1'b0);
        repeat (4) cycle();
        checkOutput("pre_reset_busy", 64'(busy), 1);
        applyStimulus(1'b1, 1'b0, 3'b001, 3'b000, 1'b0);
        cycle();
        checkResetValues("midwait_rst");
        applyStimulus(1'b0, 1'b0, 3'b001, 3'b001, 1'b0);
        cycle();
        applyStimulus(1'b0, 1'b0, 3'b001, 3'b000, 1'b0);
        cycle();
        checkOutput("late_done_frame_cnt", 64'(frame_cnt), 0);
        checkOutput("late_done_busy", 64'(busy), 0);
        checkOutput("late_done_start", 64'(step_start), 0);

        checkOutput("start_onehot_in_issue", 64'(bad_start), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
